aes_shift_mix_stage: RTL and testbench
======================================

# aes_shift_mix_stage

Round stage directly downstream of the SubBytes stage in the AES datapath. Accepts the 128-bit substituted state, applies ShiftRows on capture, then computes MixColumns iteratively, one column per cycle, over four cycles. Presents the result to the AddRoundKey stage. Handshaking is valid/ready on both sides, and the block has a global clock-gating style `enable`.

## Interface
Parameters:
- `COLS`, 4: columns per state. Fixed for AES and must not be overridden.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  when low the stage is frozen (see Operation).
- `in_valid`  in  1  `block_in` holds a SubBytes result.
- `in_ready`  out  1  stage can capture `block_in` this cycle.
- `block_in`  in  [0:127]  state, byte i = bits [8i:8i+7], bit 8i = MSB.
- `out_valid`  out  1  `block_out` holds a completed ShiftRows+MixColumns result.
- `out_ready`  in  1  downstream accepts `block_out`.
- `block_out`  out  [0:127]  result, same byte order as `block_in`.
- `busy`  out  1  FSM is in MIX.
- `final_round`  in  1  present only with `AES_FINAL_ROUND_EN`; sampled with `block_in`.

## Operation
- State mapping: byte i is at row i%4, column i/4 (FIPS-197 column-major).
- ShiftRows on capture: `sr[4c+r] = block_in[4*((c+r)%4)+r]`.
- MixColumns per column (a0..a3), all GF(2^8):
  - `b0 = 2a0^3a1^a2^a3`
  - `b1 = a0^2a1^3a2^a3`
  - `b2 = a0^a1^2a2^3a3`
  - `b3 = 3a0^a1^a2^2a3`
  - `xtime(a) = (a<<1) ^ (a[msb] ? 8'h1b : 0)`, with the result kept at 8 bits.
  - `3a = xtime(a)^a`.
- FSM:
  - IDLE: `in_ready=1`. On `in_valid&in_ready` (enable high), register the ShiftRows result into `st`, clear `col`, and go to MIX.
  - MIX: each enabled cycle, replace column `col` of `st` with its mixed value and increment `col` (2-bit counter). After `col==3` is processed, go to DONE.
  - DONE: `out_valid=1`, `block_out=st`.
    - On `out_ready`, the transfer completes.
    - `in_ready = out_ready` in DONE. A simultaneous accept captures the new block and goes to MIX; otherwise the FSM goes to IDLE.
    - With `out_ready` low, hold DONE and keep `block_out` stable.
- `enable` low:
  - All registers hold.
  - `in_ready` and `out_valid` are forced to 0, so no transfer happens on either side.
  - Resuming `enable` continues from the exact held state and column.
- Reset, asynchronous at any time including mid-MIX: FSM to IDLE, `col=0`, `st=0`. Any partial block is discarded.
- Output values during reset: `block_out=0`, `out_valid=0`, `busy=0`. `in_ready=0` while reset is asserted and `in_ready=1` from the first cycle after release.

## Timing
- Capture at edge T. Columns 0..3 are mixed at edges T+1..T+4. `out_valid` is high from the cycle after edge T+4: 4 cycles of latency after capture.
- Throughput with `out_ready` held high: one block every 5 cycles (back-to-back accept in DONE).
- `block_out` is registered; there is no combinational path from `block_in` or `out_ready` to `block_out`.
- `in_ready` depends combinationally on `out_ready` only in DONE.
- Each `enable`-low cycle adds exactly one cycle to the latency.

## Configuration
- `AES_FINAL_ROUND_EN` defined:
  - The `final_round` port exists and is sampled at capture.
  - If it is set, the FSM goes IDLE→DONE directly: ShiftRows only, `out_valid` one cycle after capture. This is the AES last round.
- `AES_FINAL_ROUND_EN` undefined: the port is absent and every block goes through MIX.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_W=128`, `AES_BYTE_W=8`.
  - `AES_POLY=8'h1b`.
  - `xtime` function.
  - FSM state enum {IDLE, MIX, DONE}.
  - 32-bit column type.
- One sub-module `aes_mix_column`: combinational 32-bit in/out single-column MixColumns. It is instantiated once and time-multiplexed via `col`.

## Test plan
- Column check: force a capture whose column 0 after ShiftRows is `db 13 53 45` → output column 0 = `8e 4d a1 bc`.
- FIPS-197 App. B round 1: `block_in=d42711aee0bf98f1b8b45de51e415230`, `out_ready=1` → `block_out=046681e5e0cb199a48f8d37a2806264c`, `out_valid` rises 4 cycles after capture.
- All-zero block → all-zero output. Block of all `01` → all `01`.
- Backpressure: `out_ready=0` for 10 cycles in DONE → `block_out` stable and `in_ready=0`. Raise `out_ready` with `in_valid` high → the new block is captured in the same cycle.
- Enable/reset mid-MIX:
  - Drop `enable` for 3 cycles at `col=2` → same result, latency +3.
  - Assert `reset` at `col=1` → all outputs 0, FSM in IDLE, `in_ready=1` the cycle after release.
- With `AES_FINAL_ROUND_EN`, `final_round=1`: `block_in=d42711ae...5230` → `block_out=d4bf5d30e0b452aeb84111f11e2798e5` one cycle after capture.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers: block/byte widths, reduction polynomial,
// xtime, the stage FSM encoding and the 32-bit column type.
package aes_pkg;

  localparam int         AES_BLOCK_W = 128;
  localparam int         AES_BYTE_W  = 8;
  localparam logic [7:0] AES_POLY    = 8'h1b;

  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    MIX,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Single-column MixColumns, purely combinational (0 cycles); no handshake of its own.
// Row 0 of the column sits in bits [31:24].
module aes_mix_column
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // 3a = xtime(a) ^ a
  assign col_out[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
  assign col_out[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_shift_mix_stage.sv
// ShiftRows on capture, then MixColumns one column per cycle: 4 cycles capture-to-valid, valid/ready both sides.
// Optional AES_FINAL_ROUND_EN adds final_round, which skips MIX (1 cycle latency); enable low freezes all state.
module aes_shift_mix_stage
  import aes_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_BLOCK_W-1] block_in,
`ifdef AES_FINAL_ROUND_EN
  input  logic                   final_round,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_BLOCK_W-1] block_out,
  output logic                   busy
);

  state_t                 state, state_nxt;
  logic [1:0]             col;
  logic [0:AES_BLOCK_W-1] st, sr;
  col_t                   mix_in, mix_out;
  logic                   capture, skip_mix;

`ifdef AES_FINAL_ROUND_EN
  assign skip_mix = final_round;
`else
  assign skip_mix = 1'b0;
`endif

  always_comb begin
    sr = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[AES_BYTE_W*(4*c+r) +: AES_BYTE_W] = block_in[AES_BYTE_W*(4*((c+r)%COLS)+r) +: AES_BYTE_W];
      end
    end
  end

  assign mix_in = st[32*int'(col) +: 32];

  aes_mix_column u_mix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  // in_ready is held low through reset even though state already reads IDLE
  assign in_ready  = !reset && enable && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = enable && (state == DONE);
  assign busy      = (state == MIX);
  assign block_out = st;
  assign capture   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        IDLE: if (capture) state_nxt = skip_mix ? DONE : MIX;
        MIX:  if (col == 2'd3) state_nxt = DONE;
        DONE: if (out_ready) state_nxt = capture ? (skip_mix ? DONE : MIX) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st  <= '0;
      col <= 2'd0;
    end else if (enable) begin
      if (capture) begin
        st  <= sr;
        col <= 2'd0;
      end else if (state == MIX) begin
        st[32*int'(col) +: 32] <= mix_out;
        col                    <= col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// Bench for aes_shift_mix_stage: directed FIPS vectors plus randomized blocks against a
// matrix-form AES round model; final-round case only when AES_FINAL_ROUND_EN is defined.
module tb_aes_shift_mix_stage;

  logic         clock = 1'b0;
  logic         reset, enable, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] block_in, block_out;
`ifdef AES_FINAL_ROUND_EN
  logic         final_round;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  aes_shift_mix_stage dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .block_in    (block_in),
`ifdef AES_FINAL_ROUND_EN
    .final_round (final_round),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .block_out   (block_out),
    .busy        (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((k >> i) & 1) != 0) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_round(input logic [0:127] b, input bit mix);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   acc;
    logic [0:127] o;
    int           coef [4];
    coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = b[8*(4*c+r) +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r][c] = s[r][(c+r)%4];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (mix) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(t[k][c], coef[(k-r+4)%4]);
        end else begin
          acc = t[r][c];
        end
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [0:127] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [0:127] blk, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    block_in = blk;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; block_in = '0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, block_out} !== 131'd0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b out=%h, want all 0", in_ready, out_valid, busy, block_out);
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_column();
    logic [0:127] blk;
    bit ok; int lat;
    blk = rand_blk();
    blk[0:7] = 8'hdb; blk[40:47] = 8'h13; blk[80:87] = 8'h53; blk[120:127] = 8'h45;
    capture(blk, ok);
    wait_out(lat);
    n_checks++;
    if (!ok || lat != 4) begin n_fail++; $display("FAIL column_timing: ok=%b lat=%0d, want 1 4", ok, lat); end
    n_checks++;
    if (block_out[0:31] !== 32'h8e4da1bc) begin n_fail++; $display("FAIL column0: got %h want 8e4da1bc", block_out[0:31]); end
    n_checks++;
    if (block_out !== ref_round(blk, 1'b1)) begin n_fail++; $display("FAIL column_block: got %h want %h", block_out, ref_round(blk, 1'b1)); end
    tick();
  endtask

  task automatic test_fips();
    bit ok; int lat;
    out_ready = 1'b1;
    capture(128'hd42711aee0bf98f1b8b45de51e415230, ok);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_mix_entry: busy=%b vld=%b, want 1 0", busy, out_valid); end
    wait_out(lat);
    n_checks++;
    if (!ok || lat != 4) begin n_fail++; $display("FAIL fips_latency: ok=%b lat=%0d, want 1 4", ok, lat); end
    n_checks++;
    if (block_out !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
      n_fail++; $display("FAIL fips_block: got %h want 046681e5e0cb199a48f8d37a2806264c", block_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_to_idle: vld=%b rdy=%b, want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_patterns();
    logic [0:127] pats [2];
    bit ok; int lat;
    pats[0] = '0;
    pats[1] = {16{8'h01}};
    for (int i = 0; i < 2; i++) begin
      capture(pats[i], ok);
      wait_out(lat);
      n_checks++;
      if (!ok || lat != 4 || block_out !== pats[i]) begin
        n_fail++; $display("FAIL pattern%0d: ok=%b lat=%0d got %h want %h", i, ok, lat, block_out, pats[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] a, b;
    bit ok; int lat;
    a = rand_blk(); b = rand_blk();
    out_ready = 1'b0;
    capture(a, ok);
    wait_out(lat);
    n_checks++;
    if (!ok || lat != 4) begin n_fail++; $display("FAIL bp_latency: ok=%b lat=%0d, want 1 4", ok, lat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, block_out} !== {2'b10, ref_round(a, 1'b1)}) begin
        n_fail++; $display("FAIL bp_hold%0d: vld=%b rdy=%b out=%h want 1 0 %h", i, out_valid, in_ready, block_out, ref_round(a, 1'b1));
      end
    end
    in_valid = 1'b1; block_in = b; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_follow: rdy=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_same_cycle_capture: busy=%b want 1", busy); end
    wait_out(lat);
    n_checks++;
    if (lat != 4 || block_out !== ref_round(b, 1'b1)) begin
      n_fail++; $display("FAIL bp_second: lat=%0d got %h want 4 %h", lat, block_out, ref_round(b, 1'b1));
    end
    tick();
  endtask

  task automatic test_enable();
    logic [0:127] blk;
    bit ok; int lat;
    blk = rand_blk();
    out_ready = 1'b1;
    capture(blk, ok);
    tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL en_freeze%0d: busy=%b vld=%b want 1 0", i, busy, out_valid); end
    end
    enable = 1'b1;
    wait_out(lat);
    n_checks++;
    if (!ok || lat != 2) begin n_fail++; $display("FAIL en_latency: total=%0d want 7", (lat < 0) ? -1 : lat + 5); end
    n_checks++;
    if (block_out !== ref_round(blk, 1'b1)) begin n_fail++; $display("FAIL en_block: got %h want %h", block_out, ref_round(blk, 1'b1)); end
    enable = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL en_gate: vld=%b rdy=%b want 0 0", out_valid, in_ready); end
    tick();
    enable = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || block_out !== ref_round(blk, 1'b1)) begin
      n_fail++; $display("FAIL en_no_transfer: vld=%b got %h want 1 %h", out_valid, block_out, ref_round(blk, 1'b1));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    capture(rand_blk(), ok);
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({block_out, out_valid, busy, in_ready} !== 131'd0) begin
      n_fail++; $display("FAIL rst_mid: out=%h vld=%b busy=%b rdy=%b want all 0", block_out, out_valid, busy, in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release: rdy=%b busy=%b want 1 0", in_ready, busy); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || block_out !== '0) begin
      n_fail++; $display("FAIL rst_mid_discard: vld=%b busy=%b out=%h want 0 0 0", out_valid, busy, block_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] exp_q [$];
    int sent, got, last, nblk;
    bit cap;
    sent = 0; got = 0; last = -1; nblk = 5;
    enable = 1'b1; out_ready = 1'b1;
    block_in = rand_blk(); in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && got < nblk; cyc++) begin
      cap = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0 || block_out !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h", got, block_out);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 5) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 5", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (cap) begin
        exp_q.push_back(ref_round(block_in, 1'b1));
        sent++;
      end
      tick();
      if (cap) begin
        block_in = rand_blk();
        in_valid = (sent < nblk);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != nblk) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got, nblk); end
  endtask

  task automatic test_random_stall();
    logic [0:127] exp_q [$];
    int sent, got, nblk;
    bit cap;
    sent = 0; got = 0; nblk = 12;
    block_in = rand_blk(); in_valid = 1'b0;
    for (int cyc = 0; cyc < 2000 && got < nblk; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if (!in_valid && sent < nblk) in_valid = $urandom_range(0, 1);
      #1;
      cap = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0 || block_out !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_data%0d: got %h", got, block_out);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (cap) begin
        exp_q.push_back(ref_round(block_in, 1'b1));
        sent++;
      end
      tick();
      if (cap) begin
        block_in = rand_blk();
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    n_checks++;
    if (got != nblk) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got, nblk); end
    tick();
  endtask

`ifdef AES_FINAL_ROUND_EN
  task automatic test_final_round();
    bit ok; int lat;
    final_round = 1'b1;
    out_ready   = 1'b1;
    capture(128'hd42711aee0bf98f1b8b45de51e415230, ok);
    final_round = 1'b0;
    n_checks++;
    if (!ok || out_valid !== 1'b1) begin n_fail++; $display("FAIL final_latency: ok=%b vld=%b want 1 1", ok, out_valid); end
    n_checks++;
    if (block_out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      n_fail++; $display("FAIL final_block: got %h want d4bf5d30e0b452aeb84111f11e2798e5", block_out);
    end
    tick();
  endtask
`endif

  initial begin
`ifdef AES_FINAL_ROUND_EN
    final_round = 1'b0;
`endif
    test_reset();
    test_column();
    test_fips();
    test_patterns();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_random_stall();
`ifdef AES_FINAL_ROUND_EN
    test_final_round();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
